mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Memory access initiator: the MAR/MDR controller that drives the synchronous LC-3 unified memory.
//  Accepts one load/store request at a time from the datapath and issues a single MIO_EN cycle to memory.
//  Captures read data one cycle later and returns it with a one-cycle response pulse.
//  Decodes the LC-3 memory-mapped I/O page (KBSR/KBDR/DSR/DDR); those accesses never reach memory.
// PARAMETERS
//  MMIO_BASE  16'hFE00  base of the I/O page; addr[15:8]==MMIO_BASE[15:8] selects I/O
//  DSR_RST    1'b1      value of display-ready (DSR[15]) after reset
// PORTS
//  clk        in   1   rising-edge clock
//  rst        in   1   synchronous, active-high reset
//  req_valid  in   1   datapath request; sampled only when req_ready=1
//  req_ready  out  1   1 in IDLE (combinational from state)
//  req_we     in   1   1=store, 0=load
//  req_addr   in   16  MAR value
//  req_wdata  in   16  MDR value for stores
//  resp_valid out  1   one-cycle pulse: access complete
//  resp_rdata out  16  MDR; load data (stores return the written value)
//  MIO_EN     out  1   memory enable, registered
//  R_W        out  1   1=write, registered
//  mem_a      out  16  memory address, registered
//  mem_wdata  out  16  to memory d_in, registered
//  mem_rdata  in   16  from memory d_out (valid the cycle after MIO_EN)
//  kbd_strobe in   1   keyboard char arrives this cycle
//  kbd_data   in   8   keyboard char
//  disp_valid out  1   one-cycle pulse: char for display
//  disp_data  out  8   display char, held until next DDR write
//  disp_ack   in   1   display consumed char; sets DSR ready
// BEHAVIOUR
//  Reset: state=IDLE, MIO_EN=0, R_W=0, mem_a=0, mem_wdata=0, resp_valid=0, resp_rdata=0,
//    disp_valid=0, disp_data=0, kbd_full=0, kbd_char=0, dsr_ready=DSR_RST.
//  States: IDLE, MEM, CAP, IO, RESP.
//  IDLE: req_ready=1; on req_valid latch addr/we/wdata into MAR/MDR/WE.
//    I/O address -> IO; otherwise -> MEM. MIO_EN=1 is registered into the MEM cycle.
//  MEM (acceptance cycle +1): MIO_EN=1, R_W=WE, mem_a=MAR, mem_wdata=MDR. Next state CAP; MIO_EN=0 leaving MEM.
//  CAP (+2): if !WE, MDR<=mem_rdata; next state RESP.
//  IO (+1), by address:
//    FE00 KBSR: read {kbd_full,15'b0}.
//    FE02 KBDR: read {8'h00,kbd_char} and clear kbd_full.
//    FE04 DSR: read {dsr_ready,15'b0}.
//    FE06 DDR: write with dsr_ready=1 -> disp_valid pulse, disp_data=MDR[7:0], dsr_ready<=0;
//      write with dsr_ready=0 is dropped. A DDR read returns 0.
//    Writes to KBSR/KBDR/DSR are ignored. Other I/O-page addresses read 0 and drop writes.
//    Next state RESP.
//  RESP: resp_valid=1, resp_rdata=MDR; next state IDLE.
//  Latency: memory access 3 cycles accept->resp_valid; I/O access 2 cycles. Back-to-back rate is one request per 4 (mem) or 3 (I/O) cycles.
//  Keyboard: kbd_strobe sets kbd_full=1 and kbd_char=kbd_data; a new char overwrites an unread char.
//  Same cycle as a KBDR read: read returns the old char, the strobe wins (kbd_full=1, new char stored).
//  disp_ack sets dsr_ready=1. If disp_ack coincides with a DDR write while busy, the write is dropped and ready is set.
//  Memory/I-O ordering: only one access is outstanding; MIO_EN never asserts in IO/RESP/IDLE.
//  Reset mid-operation: next cycle state=IDLE, MIO_EN=0, no resp_valid for the aborted request.
//    A store whose MEM edge already occurred stays committed in memory.
//  Addresses are full 16-bit; no wrap or alignment rules (word-addressed).
// TESTING
//  1 Load x3000 with mem[x3000]=x1265: req at cyc0 -> MIO_EN=1,R_W=0,mem_a=x3000 at cyc1; resp_valid at cyc3, rdata=x1265.
//  2 Store x4000<-xBEEF then load x4000: MIO_EN,R_W=1,mem_wdata=xBEEF at cyc1; the load returns xBEEF; req_ready=0 for cycles 1-3 of each access.
//  3 kbd_strobe 'A'(x41); read KBSR->x8000; read KBDR->x0041; read KBSR->x0000; MIO_EN stays 0 throughout.
//  4 Write DDR x0048: disp_valid 1 cycle, disp_data=x48, DSR reads x0000; 2nd DDR write is dropped (no pulse); disp_ack -> DSR reads x8000.
//  5 kbd_strobe x42 same cycle as KBDR read with kbd_char=x41: read returns x0041, then KBSR=x8000, KBDR=x0042.
//  6 Assert rst during CAP of a load: next cycle IDLE, req_ready=1, MIO_EN=0, no resp_valid; a following load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// LC-3 MAR/MDR memory access controller: one outstanding load/store to synchronous
// unified memory, with the memory-mapped keyboard/display I/O page decoded locally.
module mem_access_ctrl #(
  parameter logic [15:0] MMIO_BASE = 16'hFE00,
  parameter logic        DSR_RST   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        MIO_EN,
  output logic        R_W,
  output logic [15:0] mem_a,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        kbd_strobe,
  input  logic [7:0]  kbd_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ack
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  localparam logic [AW-1:0] KBSR_ADDR = MMIO_BASE;
  localparam logic [AW-1:0] KBDR_ADDR = MMIO_BASE + AW'(2);
  localparam logic [AW-1:0] DSR_ADDR  = MMIO_BASE + AW'(4);
  localparam logic [AW-1:0] DDR_ADDR  = MMIO_BASE + AW'(6);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MEM  = 3'd1,
    S_CAP  = 3'd2,
    S_IO   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mar_q, mar_d;
  logic [DW-1:0] mdr_q, mdr_d;
  logic          we_q, we_d;
  logic          mio_en_q, mio_en_d;
  logic          r_w_q, r_w_d;
  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic          disp_valid_q, disp_valid_d;
  logic [CW-1:0] disp_data_q, disp_data_d;
  logic          kbd_full_q, kbd_full_d;
  logic [CW-1:0] kbd_char_q, kbd_char_d;
  logic          dsr_ready_q, dsr_ready_d;
  logic [DW-1:0] io_rdata;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mar_q        <= '0;
      mdr_q        <= '0;
      we_q         <= 1'b0;
      mio_en_q     <= 1'b0;
      r_w_q        <= 1'b0;
      mem_a_q      <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      kbd_full_q   <= 1'b0;
      kbd_char_q   <= '0;
      dsr_ready_q  <= DSR_RST;
    end else begin
      state_q      <= state_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      we_q         <= we_d;
      mio_en_q     <= mio_en_d;
      r_w_q        <= r_w_d;
      mem_a_q      <= mem_a_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      kbd_full_q   <= kbd_full_d;
      kbd_char_q   <= kbd_char_d;
      dsr_ready_q  <= dsr_ready_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    we_d         = we_q;
    mio_en_d     = 1'b0;
    r_w_d        = 1'b0;
    mem_a_d      = mem_a_q;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    disp_valid_d = 1'b0;
    disp_data_d  = disp_data_q;
    kbd_full_d   = kbd_full_q;
    kbd_char_d   = kbd_char_q;
    dsr_ready_d  = dsr_ready_q;
    io_rdata     = '0;

    // Ack first so a DDR write against a busy display is dropped yet ready still rises
    if (disp_ack) dsr_ready_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mar_d = req_addr;
          mdr_d = req_wdata;
          we_d  = req_we;
          if (req_addr[15:8] == MMIO_BASE[15:8]) begin
            state_d = S_IO;
          end else begin
            state_d     = S_MEM;
            mio_en_d    = 1'b1;
            r_w_d       = req_we;
            mem_a_d     = req_addr;
            mem_wdata_d = req_wdata;
          end
        end
      end
      S_MEM: state_d = S_CAP;
      S_CAP: begin
        if (!we_q) mdr_d = mem_rdata;
        resp_rdata_d = we_q ? mdr_q : mem_rdata;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_IO: begin
        if (we_q) begin
          resp_rdata_d = mdr_q;
          if (mar_q == DDR_ADDR && dsr_ready_q) begin
            disp_valid_d = 1'b1;
            disp_data_d  = mdr_q[CW-1:0];
            dsr_ready_d  = 1'b0;
          end
        end else begin
          if (mar_q == KBSR_ADDR) begin
            io_rdata = {kbd_full_q, 15'b0};
          end else if (mar_q == KBDR_ADDR) begin
            io_rdata   = {8'h00, kbd_char_q};
            kbd_full_d = 1'b0;
          end else if (mar_q == DSR_ADDR) begin
            io_rdata = {dsr_ready_q, 15'b0};
          end
          mdr_d        = io_rdata;
          resp_rdata_d = io_rdata;
        end
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A newly arriving keyboard char wins over a same-cycle KBDR clear
    if (kbd_strobe) begin
      kbd_full_d = 1'b1;
      kbd_char_d = kbd_data;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign MIO_EN     = mio_en_q;
  assign R_W        = r_w_q;
  assign mem_a      = mem_a_q;
  assign mem_wdata  = mem_wdata_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: synchronous memory model, vector table, directed corner
// sequences and randomized transactions checked against a transaction-level model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        MIO_EN, R_W;
  logic [15:0] mem_a, mem_wdata, mem_rdata;
  logic        kbd_strobe;
  logic [7:0]  kbd_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ack;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .MIO_EN(MIO_EN), .R_W(R_W), .mem_a(mem_a), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .kbd_strobe(kbd_strobe), .kbd_data(kbd_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ack(disp_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_pat(input logic [15:0] a);
    return (a == 16'h3000) ? 16'h1265 : (a ^ 16'h5A5A);
  endfunction

  // Synchronous memory: read data valid the cycle after MIO_EN
  logic [15:0] mem [0:65535];
  bit mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_pat(16'(i));
      mem_init_done <= 1'b1;
    end else if (MIO_EN) begin
      if (R_W) mem[mem_a] <= mem_wdata;
      mem_rdata <= mem[mem_a];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] ref_mem_w [logic [15:0]];
  logic        m_kfull;
  logic [7:0]  m_kchar;
  logic        m_dsr;
  logic [7:0]  m_disp_data;

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem_w.exists(a) ? ref_mem_w[a] : init_pat(a);
  endfunction

  task automatic model_reset();
    m_kfull = 1'b0; m_kchar = 8'h00; m_dsr = 1'b1; m_disp_data = 8'h00;
  endtask

  task automatic model_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input logic strobe1, input logic [7:0] sdata,
                           output logic [15:0] e_rd, output int e_lat, output int e_mio,
                           output int e_disp);
    e_disp = 0;
    if (addr[15:8] == 8'hFE) begin
      e_lat = 2; e_mio = 0;
      if (we) begin
        e_rd = wdata;
        if (addr == 16'hFE06 && m_dsr) begin
          e_disp = 1; m_disp_data = wdata[7:0]; m_dsr = 1'b0;
        end
      end else begin
        case (addr)
          16'hFE00: e_rd = {m_kfull, 15'b0};
          16'hFE02: begin e_rd = {8'h00, m_kchar}; m_kfull = 1'b0; end
          16'hFE04: e_rd = {m_dsr, 15'b0};
          default:  e_rd = 16'h0000;
        endcase
      end
    end else begin
      e_lat = 3; e_mio = 1;
      e_rd  = we ? wdata : ref_read(addr);
      if (we) ref_mem_w[addr] = wdata;
    end
    if (strobe1) begin m_kfull = 1'b1; m_kchar = sdata; end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, optionally strobing the keyboard in the first busy cycle
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic strobe1, input logic [7:0] sdata,
                        output logic [15:0] rd, output int lat, output int mio_cnt,
                        output int disp_cnt, output int busy_cnt, output logic tail_bad);
    int c;
    logic got;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    c = 0; got = 1'b0; lat = 99; rd = 16'hDEAD;
    mio_cnt = 0; disp_cnt = 0; busy_cnt = 0;
    while (!got && c < 8) begin
      c++;
      if (MIO_EN) mio_cnt++;
      if (disp_valid) disp_cnt++;
      if (!req_ready) busy_cnt++;
      if (resp_valid) begin
        got = 1'b1; lat = c; rd = resp_rdata;
      end else begin
        if (c == 1) begin kbd_strobe = strobe1; kbd_data = sdata; end
        tick();
        kbd_strobe = 1'b0;
      end
    end
    tick();
    tail_bad = resp_valid | disp_valid | MIO_EN;
  endtask

  task automatic run_txn(input string tag, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic strobe1, input logic [7:0] sdata,
                         output logic [15:0] rd);
    logic [15:0] e_rd;
    int e_lat, e_mio, e_disp, lat, mio, dsp, busy;
    logic tail;
    model_txn(we, addr, wdata, strobe1, sdata, e_rd, e_lat, e_mio, e_disp);
    do_req(we, addr, wdata, strobe1, sdata, rd, lat, mio, dsp, busy, tail);
    check({tag, ".rdata"}, 32'(rd), 32'(e_rd));
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".mio_cycles"}, 32'(mio), 32'(e_mio));
    check({tag, ".busy_cycles"}, 32'(busy), 32'(e_lat));
    check({tag, ".disp_pulses"}, 32'(dsp), 32'(e_disp));
    check({tag, ".disp_data"}, 32'(disp_data), 32'(m_disp_data));
    check({tag, ".tail_quiet"}, 32'(tail), 32'(0));
  endtask

  task automatic idle_cycle(input logic strobe, input logic [7:0] sdata, input logic ack);
    kbd_strobe = strobe; kbd_data = sdata; disp_ack = ack;
    tick();
    kbd_strobe = 1'b0; disp_ack = 1'b0;
    if (strobe) begin m_kfull = 1'b1; m_kchar = sdata; end
    if (ack) m_dsr = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    int          exp_lat;
    int          exp_disp;
  } vec_t;

  vec_t tbl [13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd, e_rd;
    int lat, mio, dsp, busy, e_lat, e_mio, e_disp;
    logic tail;

    tbl[0]  = '{1'b1, 16'h4000, 16'hBEEF, 16'hBEEF, 3, 0};
    tbl[1]  = '{1'b0, 16'h4000, 16'h0000, 16'hBEEF, 3, 0};
    tbl[2]  = '{1'b0, 16'h3000, 16'h0000, 16'h1265, 3, 0};
    tbl[3]  = '{1'b0, 16'hFFFF, 16'h0000, 16'hA5A5, 3, 0};
    tbl[4]  = '{1'b0, 16'hFDFF, 16'h0000, 16'hA7A5, 3, 0};
    tbl[5]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 2, 0};
    tbl[6]  = '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 2, 0};
    tbl[7]  = '{1'b0, 16'hFE06, 16'h0000, 16'h0000, 2, 0};
    tbl[8]  = '{1'b1, 16'hFE00, 16'hFFFF, 16'hFFFF, 2, 0};
    tbl[9]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 2, 0};
    tbl[10] = '{1'b0, 16'hFEFF, 16'h0000, 16'h0000, 2, 0};
    tbl[11] = '{1'b1, 16'hFE10, 16'h1234, 16'h1234, 2, 0};
    tbl[12] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 3, 0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    kbd_strobe = 1'b0; kbd_data = '0; disp_ack = 1'b0;
    model_reset();
    tick(); tick(); tick();
    check("reset.req_ready", 32'(req_ready), 32'(1));
    check("reset.mio_en", 32'(MIO_EN), 32'(0));
    check("reset.r_w", 32'(R_W), 32'(0));
    check("reset.mem_a", 32'(mem_a), 32'(0));
    check("reset.mem_wdata", 32'(mem_wdata), 32'(0));
    check("reset.resp_valid", 32'(resp_valid), 32'(0));
    check("reset.resp_rdata", 32'(resp_rdata), 32'(0));
    check("reset.disp", 32'({disp_valid, disp_data}), 32'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) begin
      model_txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 8'h00, e_rd, e_lat, e_mio, e_disp);
      do_req(tbl[i].we, tbl[i].addr, tbl[i].wdata, 1'b0, 8'h00, rd, lat, mio, dsp, busy, tail);
      check($sformatf("vec%0d.rdata", i), 32'(rd), 32'(tbl[i].exp_rd));
      check($sformatf("vec%0d.latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(tbl[i].exp_lat));
      check($sformatf("vec%0d.disp", i), 32'(dsp), 32'(tbl[i].exp_disp));
    end

    // Load x3000: memory handshake visible in the MEM cycle
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h3000; req_wdata = 16'h0000;
    tick(); req_valid = 1'b0;
    check("ld.cyc1.mio_en", 32'(MIO_EN), 32'(1));
    check("ld.cyc1.r_w", 32'(R_W), 32'(0));
    check("ld.cyc1.mem_a", 32'(mem_a), 32'(16'h3000));
    check("ld.cyc1.req_ready", 32'(req_ready), 32'(0));
    tick();
    check("ld.cyc2.mio_en", 32'(MIO_EN), 32'(0));
    check("ld.cyc2.resp_valid", 32'(resp_valid), 32'(0));
    tick();
    check("ld.cyc3.resp_valid", 32'(resp_valid), 32'(1));
    check("ld.cyc3.rdata", 32'(resp_rdata), 32'(16'h1265));
    tick();
    check("ld.cyc4.resp_valid", 32'(resp_valid), 32'(0));
    check("ld.cyc4.req_ready", 32'(req_ready), 32'(1));

    // Store: write strobe, data and address presented together
    model_txn(1'b1, 16'h4001, 16'hBEEF, 1'b0, 8'h00, e_rd, e_lat, e_mio, e_disp);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h4001; req_wdata = 16'hBEEF;
    tick(); req_valid = 1'b0;
    check("st.cyc1.mio_rw", 32'({MIO_EN, R_W}), 32'(2'b11));
    check("st.cyc1.mem_a", 32'(mem_a), 32'(16'h4001));
    check("st.cyc1.mem_wdata", 32'(mem_wdata), 32'(16'hBEEF));
    tick(); tick();
    check("st.cyc3.resp", 32'({resp_valid, resp_rdata}), 32'({1'b1, 16'hBEEF}));
    tick();
    run_txn("st.readback", 1'b0, 16'h4001, 16'h0000, 1'b0, 8'h00, rd);

    // Keyboard status/data handshake
    idle_cycle(1'b1, 8'h41, 1'b0);
    run_txn("kbd.kbsr1", 1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, rd);
    check("kbd.kbsr1.const", 32'(rd), 32'(16'h8000));
    run_txn("kbd.kbdr", 1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, rd);
    check("kbd.kbdr.const", 32'(rd), 32'(16'h0041));
    run_txn("kbd.kbsr2", 1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, rd);
    check("kbd.kbsr2.const", 32'(rd), 32'(16'h0000));

    // Display write, busy drop, ack
    run_txn("ddr.w1", 1'b1, 16'hFE06, 16'h0048, 1'b0, 8'h00, rd);
    check("ddr.w1.data", 32'(disp_data), 32'(8'h48));
    run_txn("ddr.dsr_busy", 1'b0, 16'hFE04, 16'h0, 1'b0, 8'h00, rd);
    check("ddr.dsr_busy.const", 32'(rd), 32'(16'h0000));
    run_txn("ddr.w2_drop", 1'b1, 16'hFE06, 16'h0055, 1'b0, 8'h00, rd);
    check("ddr.w2.data_held", 32'(disp_data), 32'(8'h48));
    idle_cycle(1'b0, 8'h00, 1'b1);
    run_txn("ddr.dsr_ready", 1'b0, 16'hFE04, 16'h0, 1'b0, 8'h00, rd);
    check("ddr.dsr_ready.const", 32'(rd), 32'(16'h8000));

    // Strobe coincident with KBDR read
    idle_cycle(1'b1, 8'h41, 1'b0);
    run_txn("race.kbdr", 1'b0, 16'hFE02, 16'h0, 1'b1, 8'h42, rd);
    check("race.kbdr.const", 32'(rd), 32'(16'h0041));
    run_txn("race.kbsr", 1'b0, 16'hFE00, 16'h0, 1'b0, 8'h00, rd);
    check("race.kbsr.const", 32'(rd), 32'(16'h8000));
    run_txn("race.kbdr2", 1'b0, 16'hFE02, 16'h0, 1'b0, 8'h00, rd);
    check("race.kbdr2.const", 32'(rd), 32'(16'h0042));

    // Reset during CAP of a load
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h3000; req_wdata = 16'h0000;
    tick(); req_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    check("rstcap.req_ready", 32'(req_ready), 32'(1));
    check("rstcap.mio_en", 32'(MIO_EN), 32'(0));
    check("rstcap.resp_valid", 32'(resp_valid), 32'(0));
    tick();
    check("rstcap.resp_valid2", 32'(resp_valid), 32'(0));
    run_txn("rstcap.reload", 1'b0, 16'h3000, 16'h0, 1'b0, 8'h00, rd);
    check("rstcap.reload.const", 32'(rd), 32'(16'h1265));

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      logic        we, st;
      logic [15:0] a, wd;
      logic [7:0]  sd;
      int n_idle;
      n_idle = int'($urandom_range(0, 3));
      for (int k = 0; k < n_idle; k++)
        idle_cycle(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom_range(0, 3) == 0));
      we = 1'($urandom);
      wd = 16'($urandom);
      st = 1'($urandom_range(0, 4) == 0);
      sd = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        if ($urandom_range(0, 1) == 0) a = 16'h5000 + 16'($urandom_range(0, 7));
        else begin
          a = 16'($urandom);
          if (a[15:8] == 8'hFE) a[15:8] = 8'h12;
        end
      end else begin
        case ($urandom_range(0, 5))
          0: a = 16'hFE00;
          1: a = 16'hFE02;
          2: a = 16'hFE04;
          3: a = 16'hFE06;
          4: a = 16'hFE01;
          default: a = {8'hFE, 8'($urandom)};
        endcase
      end
      run_txn($sformatf("rnd%0d", t), we, a, wd, st, sd, rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
